// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI controller slice.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_EDGES  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_ctrl_state_e;

endpackage

// File: rtl/spi_half_bit_tmr.sv
// Half-bit timer: emits a one-cycle tick every CLKS_PER_HALF_BIT cycles while
// enabled and returns to zero whenever it is disabled.
module spi_half_bit_tmr #(
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_HALF_BIT - 1);

    logic [CNT_W-1:0] halfCnt_r;

    // Half-bit counter, wraps at H-1 and clears while disabled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            halfCnt_r <= {CNT_W{1'b0}};
        end else if (!i_en) begin
            halfCnt_r <= {CNT_W{1'b0}};
        end else if (halfCnt_r == CNT_LAST) begin
            halfCnt_r <= {CNT_W{1'b0}};
        end else begin
            halfCnt_r <= halfCnt_r + CNT_W'(1);
        end
    end

    assign o_tick = i_en && (halfCnt_r == CNT_LAST);

endmodule

// File: rtl/spi_controller.sv
// Mode 0 SPI controller, one byte per CS frame, MSB first.
// Optional SPI_CONTROLLER_CS_HOLD_EN: accept the next byte during HOLD and keep CS_n low.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_INACTIVE_CLKS  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_txDataValid,
    input  logic [SPI_BYTE_W-1:0] i_txData,
    output logic                  o_txReady,
    output logic                  o_rxDataValid,
    output logic [SPI_BYTE_W-1:0] o_rxData,
    output logic                  o_SPI_CLK,
    output logic                  o_SPI_PICO,
    output logic                  o_SPI_CS_n,
    input  logic                  i_SPI_POCI
);

    localparam int GAP_W = $clog2(CS_INACTIVE_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_INACTIVE_CLKS - 1);
    localparam logic [3:0]       EDGE_LAST = 4'(SPI_EDGES - 1);
`ifdef SPI_CONTROLLER_CS_HOLD_EN
    localparam logic HOLD_READY = 1'b1;
`else
    localparam logic HOLD_READY = 1'b0;
`endif

    spi_ctrl_state_e         state_r,   state_s;
    logic [SPI_BYTE_W-2:0]   txShift_r, txShift_s;
    logic [SPI_BYTE_W-1:0]   rxShift_r, rxShift_s;
    logic [SPI_BYTE_W-1:0]   rxData_r,  rxData_s;
    logic [3:0]              edgeCnt_r, edgeCnt_s;
    logic [GAP_W-1:0]        gapCnt_r,  gapCnt_s;
    logic sclk_r, sclk_s, pico_r, pico_s, csN_r, csN_s;
    logic txReady_r, txReady_s, rxValid_r, rxValid_s;
    logic accept_s, holdAccept_s, tmrEn_s, tick_s;

    assign accept_s = i_txDataValid && txReady_r;
`ifdef SPI_CONTROLLER_CS_HOLD_EN
    assign holdAccept_s = accept_s && (state_r == HOLD);
`else
    assign holdAccept_s = 1'b0;
`endif
    // A byte taken in HOLD restarts the half-bit timing from zero
    assign tmrEn_s = ((state_r == SETUP) || (state_r == XFER) || (state_r == HOLD)) && !holdAccept_s;

    spi_half_bit_tmr #(.CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)) u_tmr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (tmrEn_s),
        .o_tick (tick_s)
    );

    // Next-state and next-output logic
    always_comb begin
        state_s   = state_r;
        txShift_s = txShift_r;
        rxShift_s = rxShift_r;
        rxData_s  = rxData_r;
        edgeCnt_s = edgeCnt_r;
        gapCnt_s  = gapCnt_r;
        sclk_s    = sclk_r;
        pico_s    = pico_r;
        csN_s     = csN_r;
        txReady_s = txReady_r;
        rxValid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s   = SETUP;
                    txShift_s = i_txData[SPI_BYTE_W-2:0];
                    pico_s    = i_txData[SPI_BYTE_W-1];
                    csN_s     = 1'b0;
                    txReady_s = 1'b0;
                    edgeCnt_s = 4'd0;
                end else begin
                    txReady_s = 1'b1;
                end
            end
            SETUP: begin
                if (tick_s) begin
                    state_s   = XFER;
                    sclk_s    = 1'b1;
                    rxShift_s = {rxShift_r[SPI_BYTE_W-2:0], i_SPI_POCI};
                    edgeCnt_s = 4'd1;
                end else begin
                    sclk_s = 1'b0;
                end
            end
            XFER: begin
                if (!tick_s) begin
                    edgeCnt_s = edgeCnt_r;
                end else if (!edgeCnt_r[0]) begin
                    sclk_s    = 1'b1;
                    rxShift_s = {rxShift_r[SPI_BYTE_W-2:0], i_SPI_POCI};
                    edgeCnt_s = edgeCnt_r + 4'd1;
                end else if (edgeCnt_r == EDGE_LAST) begin
                    state_s   = HOLD;
                    sclk_s    = 1'b0;
                    edgeCnt_s = 4'd0;
                    rxValid_s = 1'b1;
                    rxData_s  = rxShift_r;
                    txReady_s = HOLD_READY;
                end else begin
                    sclk_s    = 1'b0;
                    pico_s    = txShift_r[SPI_BYTE_W-2];
                    txShift_s = {txShift_r[SPI_BYTE_W-3:0], 1'b0};
                    edgeCnt_s = edgeCnt_r + 4'd1;
                end
            end
            HOLD: begin
                if (holdAccept_s) begin
                    state_s   = SETUP;
                    txShift_s = i_txData[SPI_BYTE_W-2:0];
                    pico_s    = i_txData[SPI_BYTE_W-1];
                    txReady_s = 1'b0;
                end else if (tick_s) begin
                    state_s   = GAP;
                    csN_s     = 1'b1;
                    pico_s    = 1'b0;
                    txReady_s = 1'b0;
                    gapCnt_s  = {GAP_W{1'b0}};
                end else begin
                    csN_s = 1'b0;
                end
            end
            GAP: begin
                if (gapCnt_r == GAP_LAST) begin
                    state_s   = IDLE;
                    txReady_s = 1'b1;
                end else begin
                    gapCnt_s = gapCnt_r + GAP_W'(1);
                end
            end
            default: begin
                state_s   = IDLE;
                csN_s     = 1'b1;
                sclk_s    = 1'b0;
                pico_s    = 1'b0;
                txReady_s = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= IDLE;
            txShift_r <= {(SPI_BYTE_W-1){1'b0}};
            rxShift_r <= {SPI_BYTE_W{1'b0}};
            rxData_r  <= {SPI_BYTE_W{1'b0}};
            edgeCnt_r <= 4'd0;
            gapCnt_r  <= {GAP_W{1'b0}};
            sclk_r    <= 1'b0;
            pico_r    <= 1'b0;
            csN_r     <= 1'b1;
            txReady_r <= 1'b1;
            rxValid_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            txShift_r <= txShift_s;
            rxShift_r <= rxShift_s;
            rxData_r  <= rxData_s;
            edgeCnt_r <= edgeCnt_s;
            gapCnt_r  <= gapCnt_s;
            sclk_r    <= sclk_s;
            pico_r    <= pico_s;
            csN_r     <= csN_s;
            txReady_r <= txReady_s;
            rxValid_r <= rxValid_s;
        end
    end

    assign o_txReady     = txReady_r;
    assign o_rxDataValid = rxValid_r;
    assign o_rxData      = rxData_r;
    assign o_SPI_CLK     = sclk_r;
    assign o_SPI_PICO    = pico_r;
    assign o_SPI_CS_n    = csN_r;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench: instance A (H=2) with loopback or peripheral model, instance B (H=5) in loopback.
module tb_spi_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef SPI_CONTROLLER_CS_HOLD_EN
    localparam logic HOLD_EN = 1'b1;
`else
    localparam logic HOLD_EN = 1'b0;
`endif

    logic validA = 1'b0, validB = 1'b0;
    logic [7:0] dataA = 8'h00, dataB = 8'h00;
    logic readyA, rxValidA, sclkA, picoA, csA, pociA;
    logic readyB, rxValidB, sclkB, picoB, csB;
    logic [7:0] rxDataA, rxDataB;
    logic loopA = 1'b1;

    spi_controller #(.CLKS_PER_HALF_BIT(2), .CS_INACTIVE_CLKS(4)) dutA (
        .i_clk(clk), .i_rst(rst), .i_txDataValid(validA), .i_txData(dataA),
        .o_txReady(readyA), .o_rxDataValid(rxValidA), .o_rxData(rxDataA),
        .o_SPI_CLK(sclkA), .o_SPI_PICO(picoA), .o_SPI_CS_n(csA), .i_SPI_POCI(pociA));

    spi_controller #(.CLKS_PER_HALF_BIT(5), .CS_INACTIVE_CLKS(4)) dutB (
        .i_clk(clk), .i_rst(rst), .i_txDataValid(validB), .i_txData(dataB),
        .o_txReady(readyB), .o_rxDataValid(rxValidB), .o_rxData(rxDataB),
        .o_SPI_CLK(sclkB), .o_SPI_PICO(picoB), .o_SPI_CS_n(csB), .i_SPI_POCI(picoB));

    // Mode 0 peripheral model: drives next bit after each SCLK fall, samples PICO on rises
    logic [7:0] pPre = 8'h3C;
    logic [7:0] pRx;
    int falls = 0;
    logic pPoci;
    always @(negedge sclkA or posedge csA) begin
        if (csA) falls <= 0;
        else     falls <= falls + 1;
    end
    always @(posedge sclkA) pRx <= {pRx[6:0], picoA};
    assign pPoci = (falls < 8) ? pPre[3'(7 - falls)] : 1'b0;
    assign pociA = loopA ? picoA : pPoci;

    int nChecks = 0, nFails = 0;
    logic [7:0] qA[$], qB[$];
    logic prevValidA = 1'b0, prevValidB = 1'b0;
    logic csArr[128], sclkArr[128], picoArr[128], readyArr[128], validArr[128];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop and compare on every rx pulse
    always @(negedge clk) begin
        if (rxValidA === 1'b1) begin
            check("rxA_one_cycle_pulse", 32'(prevValidA), 32'd0);
            if (qA.size() == 0) check("rxA_unexpected_pulse", 32'(qA.size()), 32'd1);
            else                check("rxA_data", 32'(rxDataA), 32'(qA.pop_front()));
        end
        if (rxValidB === 1'b1) begin
            check("rxB_one_cycle_pulse", 32'(prevValidB), 32'd0);
            if (qB.size() == 0) check("rxB_unexpected_pulse", 32'(qB.size()), 32'd1);
            else                check("rxB_data", 32'(rxDataB), 32'(qB.pop_front()));
        end
        prevValidA <= rxValidA;
        prevValidB <= rxValidB;
    end

    task automatic send(input logic useB, input logic [7:0] d, input logic pushExp);
        logic ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((useB ? readyB : readyA) === 1'b1) begin ok = 1'b1; break; end
        end
        check("send_ready_wait", 32'(ok), 32'd1);
        if (pushExp) begin
            if (useB) qB.push_back(d); else qA.push_back(d);
        end
        if (useB) begin validB = 1'b1; dataB = d; end
        else      begin validA = 1'b1; dataA = d; end
        @(posedge clk);
    endtask

    // Records outputs after edges E0+0 .. E0+nT-1; optional reset pulse and extra valid injection
    task automatic observe(input logic useB, input int nT, input int rstAt, input int injAt,
                           input logic [7:0] injData);
        for (int t = 0; t < nT; t++) begin
            @(negedge clk);
            csArr[t]    = useB ? csB      : csA;
            sclkArr[t]  = useB ? sclkB    : sclkA;
            picoArr[t]  = useB ? picoB    : picoA;
            readyArr[t] = useB ? readyB   : readyA;
            validArr[t] = useB ? rxValidB : rxValidA;
            rst = (t == rstAt);
            if (useB) begin validB = (t == injAt); dataB = injData; end
            else      begin validA = (t == injAt); dataA = injData; end
        end
    endtask

    function automatic int countRises(input int n);
        int c = 0;
        for (int t = 1; t < n; t++) if (sclkArr[t] && !sclkArr[t-1]) c++;
        return c;
    endfunction

    function automatic int firstHigh(input int which, input int n);
        for (int t = 0; t < n; t++) begin
            if (which == 0 && csArr[t])    return t;
            if (which == 1 && validArr[t]) return t;
            if (which == 2 && sclkArr[t])  return t;
        end
        return -1;
    endfunction

    task automatic checkTiming(input int n, input logic expBit, input int h);
        int run = 1, rises = 0;
        for (int t = 1; t < n; t++) begin
            if (sclkArr[t] != sclkArr[t-1]) begin
                if (sclkArr[t-1]) check("sclk_high_len", 32'(run), 32'(h));
                else if (rises > 0) check("sclk_low_len", 32'(run), 32'(h));
                if (sclkArr[t]) begin
                    rises++;
                    check("pico_stable_at_rise", 32'(picoArr[t]), 32'(picoArr[t-1]));
                    check("pico_value", 32'(picoArr[t]), 32'(expBit));
                end
                run = 1;
            end else begin
                run++;
            end
        end
        check("b_rise_count", 32'(rises), 32'd8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n",    32'(csA),      32'd1);
        check("rst_sclk",    32'(sclkA),    32'd0);
        check("rst_pico",    32'(picoA),    32'd0);
        check("rst_ready",   32'(readyA),   32'd1);
        check("rst_rxvalid", 32'(rxValidA), 32'd0);
        check("rst_rxdata",  32'(rxDataA),  32'd0);
        check("rst_b_cs_n",  32'(csB),      32'd1);
        rst = 1'b0;

        // 1: loopback 0xA5
        send(1'b0, 8'hA5, 1'b1);
        observe(1'b0, 42, -1, -1, 8'h00);
        check("t1_cs_low_after_e0", 32'(csArr[0]), 32'd0);
        check("t1_first_rise", 32'(firstHigh(2, 42)), 32'd2);
        check("t1_rise_count", 32'(countRises(42)), 32'd8);
        check("t1_rx_pulse_time", 32'(firstHigh(1, 42)), 32'd32);
        check("t1_cs_high_time", 32'(firstHigh(0, 42)), 32'd34);
        check("t1_ready_in_hold", 32'(readyArr[32]), 32'(HOLD_EN));
        check("t1_ready_e0_37", 32'(readyArr[37]), 32'd0);
        check("t1_ready_e0_38", 32'(readyArr[38]), 32'd1);

        // 2: peripheral model preloaded with 0x3C, send 0xC3
        loopA = 1'b0;
        send(1'b0, 8'hC3, 1'b1);
        qA[qA.size()-1] = 8'h3C;
        observe(1'b0, 42, -1, -1, 8'h00);
        check("t2_periph_rx", 32'(pRx), 32'hC3);
        loopA = 1'b1;

        // 3: valid held two cycles, second ignored; re-send after gap
        send(1'b0, 8'h96, 1'b1);
        observe(1'b0, 40, -1, 0, 8'h96);
        check("t3_single_pulse", 32'(validArr[32] + 0), 32'd1);
        check("t3_ready_e0_37", 32'(readyArr[37]), 32'd0);
        check("t3_ready_e0_38", 32'(readyArr[38]), 32'd1);
        hi = 0;
        for (int t = 34; t < 40; t++) if (csArr[t]) hi++;
        send(1'b0, 8'h69, 1'b1);
        check("t3_cs_gap_ge4", 32'(hi >= 4), 32'd1);
        observe(1'b0, 42, -1, -1, 8'h00);
        check("t3_resend_cs_low", 32'(csArr[0]), 32'd0);

        // 4: reset at E0+10 aborts, then clean 0x5A transfer
        send(1'b0, 8'h77, 1'b0);
        observe(1'b0, 14, 9, -1, 8'h00);
        check("t4_cs_low_before", 32'(csArr[9]), 32'd0);
        check("t4_cs_after_rst", 32'(csArr[10]), 32'd1);
        check("t4_sclk_after_rst", 32'(sclkArr[10]), 32'd0);
        check("t4_ready_after_rst", 32'(readyArr[10]), 32'd1);
        send(1'b0, 8'h5A, 1'b1);
        observe(1'b0, 42, -1, -1, 8'h00);
        check("t4_rx_pulse_time", 32'(firstHigh(1, 42)), 32'd32);

        // 5: H=5 instance, 0xFF then 0x00
        send(1'b1, 8'hFF, 1'b1);
        observe(1'b1, 95, -1, -1, 8'h00);
        checkTiming(95, 1'b1, 5);
        send(1'b1, 8'h00, 1'b1);
        observe(1'b1, 95, -1, -1, 8'h00);
        checkTiming(95, 1'b0, 5);
        check("t5_cs_high_time", 32'(firstHigh(0, 95)), 32'd85);

`ifdef SPI_CONTROLLER_CS_HOLD_EN
        // 6: second byte accepted during HOLD keeps CS_n low
        qA.push_back(8'h22);
        send(1'b0, 8'h11, 1'b1);
        qA[qA.size()-1] = 8'h11;
        qA.push_back(8'h22);
        void'(qA.pop_front());
        observe(1'b0, 72, -1, 32, 8'h22);
        check("t6_ready_in_hold", 32'(readyArr[32]), 32'd1);
        check("t6_rise_count", 32'(countRises(72)), 32'd16);
        check("t6_cs_high_time", 32'(firstHigh(0, 72)), 32'd67);
        check("t6_second_pulse", 32'(validArr[65]), 32'd1);
`endif

        repeat (5) @(negedge clk);
        check("qA_empty", 32'(qA.size()), 32'd0);
        check("qB_empty", 32'(qB.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
